// File: rtl/seg7_anim_sequencer_if.sv
// seg7_anim_sequencer_if
//   Groups the control inputs and display outputs of seg7_anim_sequencer.
//   master : drives the controls and observes the display (testbench/host side)
//   slave  : the sequencer itself
//   Controls: ena, period_sel[7:0], mode[1:0], anim_sel[2:0], dir, step, invert
//   Display : segments[6:0] (bit0=a .. bit6=g), dp, anim_idx[2:0], frame[3:0], tick
interface seg7_anim_sequencer_if;
    logic       ena;
    logic [7:0] period_sel;
    logic [1:0] mode;
    logic [2:0] anim_sel;
    logic       dir;
    logic       step;
    logic       invert;
    logic [6:0] segments;
    logic       dp;
    logic [2:0] anim_idx;
    logic [3:0] frame;
    logic       tick;

    modport master (
        output ena, period_sel, mode, anim_sel, dir, step, invert,
        input  segments, dp, anim_idx, frame, tick
    );

    modport slave (
        input  ena, period_sel, mode, anim_sel, dir, step, invert,
        output segments, dp, anim_idx, frame, tick
    );
endinterface

// File: rtl/seg7_anim_sequencer.sv
// seg7_anim_sequencer
//   Plays up to six built-in animations on one seven-segment display.
//   Frame rate comes from a programmable divider; run modes are auto-cycle,
//   loop-one, single-step and freeze, with reverse playback and polarity control.
//   Ports:
//     clk_i   : clock
//     rst_ni  : synchronous active-low reset
//     bus     : seg7_anim_sequencer_if.slave (controls in, display/status out)
module seg7_anim_sequencer #(
    parameter int unsigned       DIV_W          = 24,
    parameter logic [DIV_W-1:0]  DEFAULT_PERIOD = DIV_W'(10_000_000),
    parameter int unsigned       NUM_ANIM       = 6
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    seg7_anim_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        MODE_AUTO   = 2'b00,
        MODE_LOOP   = 2'b01,
        MODE_STEP   = 2'b10,
        MODE_FREEZE = 2'b11
    } mode_e;

    localparam logic [2:0] LAST_ANIM = 3'(NUM_ANIM - 1);

    localparam logic [6:0] HEX [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic logic [3:0] last_frame(input logic [2:0] a);
        case (a)
            3'd0:    last_frame = 4'd9;
            3'd1:    last_frame = 4'd5;
            3'd2:    last_frame = 4'd5;
            3'd3:    last_frame = 4'd7;
            3'd4:    last_frame = 4'd5;
            3'd5:    last_frame = 4'd15;
            default: last_frame = 4'd0;
        endcase
    endfunction

    function automatic logic [6:0] pattern(input logic [2:0] a, input logic [3:0] f);
        pattern = '0;
        case (a)
            3'd0: pattern = HEX[f];
            3'd1: case (f)
                4'd0: pattern = 7'h01;  4'd1: pattern = 7'h02;  4'd2: pattern = 7'h04;
                4'd3: pattern = 7'h08;  4'd4: pattern = 7'h10;  4'd5: pattern = 7'h20;
                default: pattern = '0;
            endcase
            3'd2: case (f)
                4'd0: pattern = 7'h01;  4'd1: pattern = 7'h20;  4'd2: pattern = 7'h10;
                4'd3: pattern = 7'h08;  4'd4: pattern = 7'h04;  4'd5: pattern = 7'h02;
                default: pattern = '0;
            endcase
            3'd3: case (f)
                4'd0: pattern = 7'h01;  4'd1: pattern = 7'h02;  4'd2: pattern = 7'h40;
                4'd3: pattern = 7'h10;  4'd4: pattern = 7'h08;  4'd5: pattern = 7'h04;
                4'd6: pattern = 7'h40;  4'd7: pattern = 7'h20;
                default: pattern = '0;
            endcase
            3'd4: case (f)
                4'd0: pattern = 7'h01;  4'd1: pattern = 7'h03;  4'd2: pattern = 7'h07;
                4'd3: pattern = 7'h0F;  4'd4: pattern = 7'h1F;  4'd5: pattern = 7'h3F;
                default: pattern = '0;
            endcase
            3'd5: pattern = HEX[f];
            default: pattern = '0;
        endcase
    endfunction

    logic [DIV_W-1:0] counter_q, counter_d;
    logic [2:0]       anim_q, anim_d;
    logic [3:0]       frame_q, frame_d;
    logic [6:0]       seg_q, seg_d;
    logic             dp_q, dp_d;
    logic             tick_q, tick_d;
    logic             step_q, step_d;
    mode_e            mode_q, mode_d;

    mode_e            mode_in;
    logic [DIV_W-1:0] cmp;
    logic             advance;
    logic             seq_auto;
    logic [2:0]       rev_anim;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            counter_q <= '0;
            anim_q    <= '0;
            frame_q   <= '0;
            seg_q     <= '0;
            dp_q      <= 1'b0;
            tick_q    <= 1'b0;
            step_q    <= 1'b0;
            mode_q    <= MODE_AUTO;
        end else begin
            counter_q <= counter_d;
            anim_q    <= anim_d;
            frame_q   <= frame_d;
            seg_q     <= seg_d;
            dp_q      <= dp_d;
            tick_q    <= tick_d;
            step_q    <= step_d;
            mode_q    <= mode_d;
        end
    end

    always_comb begin
        mode_in   = mode_e'(bus.mode);
        cmp       = (bus.period_sel == 8'd0) ? DEFAULT_PERIOD
                                             : DIV_W'({bus.period_sel, 10'b0});
        // Output stage follows the current position every cycle, even when disabled.
        seg_d     = pattern(anim_q, frame_q) ^ {7{bus.invert}};
        dp_d      = (frame_q == last_frame(anim_q));
        counter_d = counter_q;
        anim_d    = anim_q;
        frame_d   = frame_q;
        tick_d    = 1'b0;
        step_d    = step_q;
        mode_d    = mode_q;
        advance   = 1'b0;
        seq_auto  = (mode_in != MODE_LOOP);
        rev_anim  = anim_q;

        if (bus.ena) begin
            step_d = bus.step;
            mode_d = mode_in;
            if (anim_q > LAST_ANIM || frame_q > last_frame(anim_q)) begin
                anim_d    = '0;
                frame_d   = '0;
                counter_d = '0;
            end else if (mode_in == MODE_LOOP && mode_q != MODE_LOOP) begin
                anim_d    = (bus.anim_sel > LAST_ANIM) ? '0 : bus.anim_sel;
                frame_d   = '0;
                counter_d = '0;
            end else begin
                case (mode_in)
                    MODE_AUTO, MODE_LOOP: begin
                        // >= rather than == so a shrinking compare cannot overrun.
                        if (counter_q >= cmp) begin
                            advance   = 1'b1;
                            counter_d = '0;
                        end else begin
                            counter_d = counter_q + DIV_W'(1);
                        end
                    end
                    MODE_STEP: begin
                        counter_d = '0;
                        advance   = bus.step & ~step_q;
                    end
                    default: counter_d = '0;
                endcase

                if (advance) begin
                    tick_d = 1'b1;
                    if (!bus.dir) begin
                        if (frame_q == last_frame(anim_q)) begin
                            frame_d = '0;
                            if (seq_auto)
                                anim_d = (anim_q == LAST_ANIM) ? '0 : anim_q + 3'd1;
                        end else begin
                            frame_d = frame_q + 4'd1;
                        end
                    end else begin
                        if (frame_q == 4'd0) begin
                            // Pick the target animation first; its length sets the new frame.
                            if (seq_auto)
                                rev_anim = (anim_q == 3'd0) ? LAST_ANIM : anim_q - 3'd1;
                            anim_d  = rev_anim;
                            frame_d = last_frame(rev_anim);
                        end else begin
                            frame_d = frame_q - 4'd1;
                        end
                    end
                end
            end
        end
    end

    assign bus.segments = seg_q;
    assign bus.dp       = dp_q;
    assign bus.anim_idx = anim_q;
    assign bus.frame    = frame_q;
    assign bus.tick     = tick_q;

endmodule

// File: tb/tb_seg7_anim_sequencer.sv
// tb_seg7_anim_sequencer
//   Directed bench for seg7_anim_sequencer with DEFAULT_PERIOD = 4.
//   Inputs change and outputs are sampled on the falling clock edge.
module tb_seg7_anim_sequencer;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    seg7_anim_sequencer_if bus ();

    seg7_anim_sequencer #(
        .DIV_W         (24),
        .DEFAULT_PERIOD(24'd4),
        .NUM_ANIM      (6)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [6:0] DIG [10] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
    };
    localparam int LOOP_FR [9] = '{1, 2, 3, 4, 5, 6, 7, 0, 1};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Waits for the next tick; n = falling edges elapsed.
    task automatic wait_tick(input int budget, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.tick !== 1'b1 && n < budget);
        check("tick_seen", bus.tick, 1);
    endtask

    // Pulses step three times (3 high, 3 low), counting ticks and back-to-back ticks.
    task automatic step_pulses(output int nt, output int dbl);
        logic prev;
        nt   = 0;
        dbl  = 0;
        prev = 1'b0;
        for (int p = 0; p < 3; p++) begin
            for (int c = 0; c < 6; c++) begin
                bus.step = (c < 3);
                @(negedge clk);
                if (bus.tick === 1'b1) nt++;
                if (bus.tick === 1'b1 && prev) dbl++;
                prev = bus.tick;
            end
        end
        bus.step = 1'b0;
    endtask

    initial begin
        int n;
        int nt;
        int dbl;
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        bus.ena = 1'b1;
        bus.period_sel = 8'd0;
        bus.mode = 2'b00;
        bus.anim_sel = 3'd0;
        bus.dir = 1'b0;
        bus.step = 1'b0;
        bus.invert = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_seg", bus.segments, 7'h00);
        check("rst_dp", bus.dp, 0);
        check("rst_tick", bus.tick, 0);
        check("rst_anim", bus.anim_idx, 0);
        check("rst_frame", bus.frame, 0);
        rst_n = 1'b1;

        // Auto-cycle forward through the digits; segments lag frame by one cycle
        for (int k = 1; k <= 10; k++) begin
            wait_tick(20, n);
            check("fwd_period", n, 5);
            check("fwd_frame", bus.frame, k % 10);
            check("fwd_anim", bus.anim_idx, (k == 10) ? 1 : 0);
            check("fwd_seg", bus.segments, DIG[k-1]);
            check("fwd_dp", bus.dp, (k == 10) ? 1 : 0);
        end
        wait_tick(20, n);
        check("a1_seg", bus.segments, 7'h01);
        check("a1_frame", bus.frame, 1);
        for (int k = 12; k <= 52; k++) wait_tick(20, n);
        check("wrap52_anim", bus.anim_idx, 0);
        check("wrap52_frame", bus.frame, 0);

        // Mid-sequence reset, then reverse playback from reset
        wait_tick(20, n);
        wait_tick(20, n);
        check("pre_rst_frame", bus.frame, 2);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_seg", bus.segments, 7'h00);
        check("mid_rst_frame", bus.frame, 0);
        check("mid_rst_anim", bus.anim_idx, 0);
        check("mid_rst_tick", bus.tick, 0);
        check("mid_rst_dp", bus.dp, 0);
        rst_n = 1'b1;
        bus.dir = 1'b1;
        wait_tick(20, n);
        check("rev_period", n, 5);
        check("rev_anim", bus.anim_idx, 5);
        check("rev_frame", bus.frame, 15);
        @(negedge clk);
        check("rev_seg", bus.segments, 7'h71);
        check("rev_dp", bus.dp, 1);

        // Loop-one on animation 3
        bus.dir = 1'b0;
        bus.anim_sel = 3'd3;
        bus.mode = 2'b01;
        @(negedge clk);
        check("loop_load_anim", bus.anim_idx, 3);
        check("loop_load_frame", bus.frame, 0);
        for (int k = 0; k < 9; k++) begin
            wait_tick(20, n);
            check("loop_frame", bus.frame, LOOP_FR[k]);
            check("loop_anim", bus.anim_idx, 3);
        end
        bus.mode = 2'b11;
        @(negedge clk);
        bus.anim_sel = 3'd7;
        bus.mode = 2'b01;
        @(negedge clk);
        check("clamp_anim", bus.anim_idx, 0);
        check("clamp_frame", bus.frame, 0);

        // Single-step: three rising edges, three one-cycle ticks
        bus.mode = 2'b10;
        step_pulses(nt, dbl);
        check("step_ticks", nt, 3);
        check("step_tick_width", dbl, 0);
        check("step_frame", bus.frame, 3);
        check("step_anim", bus.anim_idx, 0);

        // Freeze ignores step
        bus.mode = 2'b11;
        step_pulses(nt, dbl);
        check("freeze_ticks", nt, 0);
        check("freeze_frame", bus.frame, 3);

        // Programmed period 1025, then shrink compare under the running count
        bus.period_sel = 8'd1;
        bus.mode = 2'b00;
        wait_tick(1100, n);
        check("p1_first_frame", bus.frame, 4);
        wait_tick(1100, n);
        check("p1_period", n, 1025);
        check("p1_frame", bus.frame, 5);
        nt = 0;
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            if (bus.tick === 1'b1) nt++;
        end
        check("p1_no_early_tick", nt, 0);
        bus.period_sel = 8'd0;
        @(negedge clk);
        check("shrink_tick", bus.tick, 1);
        check("shrink_frame", bus.frame, 6);

        // Invert on digit 8, then freeze with ena low
        wait_tick(20, n);
        check("p4_period", n, 5);
        wait_tick(20, n);
        check("d8_frame", bus.frame, 8);
        @(negedge clk);
        check("d8_seg", bus.segments, 7'h7F);
        bus.invert = 1'b1;
        @(negedge clk);
        check("inv_seg", bus.segments, 7'h00);
        bus.ena = 1'b0;
        nt = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.tick === 1'b1) nt++;
        end
        check("ena_lo_ticks", nt, 0);
        check("ena_lo_frame", bus.frame, 8);
        bus.invert = 1'b0;
        @(negedge clk);
        check("ena_lo_seg", bus.segments, 7'h7F);
        bus.ena = 1'b1;
        wait_tick(20, n);
        check("ena_resume_n", n, 3);
        check("ena_resume_frame", bus.frame, 9);
        @(negedge clk);
        check("d9_dp", bus.dp, 1);
        check("d9_seg", bus.segments, 7'h6F);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
